// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - Valid/ready framed word stream from the burst reader to its consumer
interface fifo_burst_reader_if #(
    parameter int DataWidth = 16
);
    logic [DataWidth-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - Burst read controller for the negedge FIFO; idle-timeout partial bursts under FIFO_BURST_READER_TIMEOUT_EN
module fifo_burst_reader #(
    parameter int DataWidth     = 16,
    parameter int BurstLen      = 16,
    parameter int LenWidth      = 12,
    parameter int TimeoutCycles = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    input  logic [DataWidth-1:0] fifo_level,
    input  logic [DataWidth-1:0] fifo_data,
    output logic                 rd,
    input  logic                 flush,
    fifo_burst_reader_if.master  m_if,
    output logic                 busy,
    output logic                 burst_done
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [DataWidth-1:0] BurstLevel = DataWidth'(BurstLen);
    localparam logic [LenWidth-1:0]  BurstLenL  = LenWidth'(BurstLen);

    logic [1:0]           state_q, state_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic                 rd_q, rd_d;
    logic                 rd_last_q, rd_last_d;
    logic [1:0]           occ_q, occ_d;
    logic [DataWidth-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                 last0_q, last0_d, last1_q, last1_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic                 level_full;
    logic                 timeout_hit;
    logic                 start;
    logic [LenWidth-1:0]  start_len;
    logic [2:0]           occ_next;

    assign pop        = (occ_q != 2'd0) && m_if.m_ready;
    // Buffer occupancy as it will stand after this edge; a read issued now lands one edge later.
    assign occ_next   = {1'b0, occ_q} + {2'b0, rd_q} - {2'b0, pop};
    assign level_full = fifo_level >= BurstLevel;
    assign start_len  = level_full ? BurstLenL : fifo_level[LenWidth-1:0];
    assign start      = (state_q == StIdle) && !empty && (fifo_level != '0)
                        && (level_full || flush || timeout_hit);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

    logic [15:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == StIdle) && !start && !empty && !level_full) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign timeout_hit = idle_cnt_q >= TimeoutLimit;
`else
    // Never true; partial bursts only start from flush in this build.
    assign timeout_hit = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        rd_d      = 1'b0;
        rd_last_d = 1'b0;
        done_d    = pop && last0_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    rd_d      = 1'b1;
                    rd_last_d = (start_len == LenWidth'(1));
                    rem_d     = start_len - LenWidth'(1);
                    state_d   = (start_len == LenWidth'(1)) ? StDrain : StRead;
                end
            end
            StRead: begin
                if ((rem_q != '0) && !empty && (occ_next <= 3'd1)) begin
                    rd_d  = 1'b1;
                    rem_d = rem_q - LenWidth'(1);
                    if (rem_q == LenWidth'(1)) begin
                        rd_last_d = 1'b1;
                        state_d   = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && last0_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Two-entry output buffer; entry 0 is always the head presented downstream.
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case ({rd_q, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    data0_d = fifo_data;
                    last0_d = rd_last_q;
                end else begin
                    data1_d = fifo_data;
                    last1_d = rd_last_q;
                end
            end
            2'b01: begin
                occ_d   = occ_q - 2'd1;
                data0_d = data1_q;
                last0_d = last1_q;
                last1_d = 1'b0;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = fifo_data;
                    last0_d = rd_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = fifo_data;
                    last1_d = rd_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
            occ_q     <= 2'd0;
            data0_q   <= '0;
            data1_q   <= '0;
            last0_q   <= 1'b0;
            last1_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            rd_q      <= rd_d;
            rd_last_q <= rd_last_d;
            occ_q     <= occ_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            last0_q   <= last0_d;
            last1_q   <= last1_d;
            done_q    <= done_d;
        end
    end

    assign rd          = rd_q;
    assign m_if.m_data  = data0_q;
    assign m_if.m_last  = last0_q;
    assign m_if.m_valid = (occ_q != 2'd0);
    assign busy        = (state_q != StIdle);
    assign burst_done  = done_q;
endmodule
